// File: rtl/layer_chain_sequencer.sv
// Launches layer kernels one at a time in index order with chain-style handshakes.
// Bypassed stages are skipped, hung stages time out, and run latency is reported.
module layer_chain_sequencer #(
  parameter int NUM_STAGES = 8,
  parameter int IDX_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_idle,
  input  logic                  ap_continue,
  input  logic [NUM_STAGES-1:0] bypass_mask,
  input  logic [CNT_W-1:0]      timeout_limit,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [IDX_W-1:0]      cur_stage,
  output logic                  err,
  output logic [CNT_W-1:0]      total_cycles
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t                r_state;
  logic [NUM_STAGES-1:0] r_mask;
  logic [CNT_W-1:0]      r_limit;
  logic [IDX_W-1:0]      r_cur;
  logic [NUM_STAGES-1:0] r_start;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_total;

  state_t                w_state_nxt;
  logic [NUM_STAGES-1:0] w_mask_nxt;
  logic [CNT_W-1:0]      w_limit_nxt;
  logic [IDX_W-1:0]      w_cur_nxt;
  logic [NUM_STAGES-1:0] w_start_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_total_nxt;

  logic [IDX_W:0]        w_first;
  logic [IDX_W:0]        w_after;
  logic [IDX_W:0]        w_after_from;
  logic [CNT_W-1:0]      w_total_inc;
  logic                  w_active;
  logic                  w_cur_done;
  logic                  w_timeout;

  // Lowest non-bypassed index at or above 'first'; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] f_next_stage(input logic [NUM_STAGES-1:0] mask,
                                                   input logic [IDX_W:0] first);
    logic [IDX_W:0] res;
    res = {(IDX_W+1){1'b0}};
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if ((i >= int'(first)) && !mask[i]) begin
        res = {1'b1, IDX_W'(i)};
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_STAGES-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_STAGES-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign w_after_from = {1'b0, r_cur} + {{IDX_W{1'b0}}, 1'b1};
  assign w_first      = f_next_stage(bypass_mask, {(IDX_W+1){1'b0}});
  assign w_after      = f_next_stage(r_mask, w_after_from);
  assign w_total_inc  = (r_total == {CNT_W{1'b1}}) ? r_total : r_total + {{(CNT_W-1){1'b0}}, 1'b1};
  // An all-zero start vector in RUN is the one-cycle gap before the next launch.
  assign w_active     = |r_start;
  assign w_cur_done   = stage_done[r_cur];
  assign w_timeout    = (r_limit != {CNT_W{1'b0}}) &&
                        (r_cnt == r_limit - {{(CNT_W-1){1'b0}}, 1'b1});

  // Next-state and datapath update for the run sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_limit_nxt = r_limit;
    w_cur_nxt   = r_cur;
    w_start_nxt = r_start;
    w_cnt_nxt   = r_cnt;
    w_total_nxt = r_total;
    ap_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          ap_ready    = 1'b1;
          w_mask_nxt  = bypass_mask;
          w_limit_nxt = timeout_limit;
          w_total_nxt = {CNT_W{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
          if (w_first[IDX_W]) begin
            w_cur_nxt   = w_first[IDX_W-1:0];
            w_start_nxt = f_onehot(w_first[IDX_W-1:0]);
            w_state_nxt = S_RUN;
          end else begin
            w_cur_nxt   = {IDX_W{1'b0}};
            w_start_nxt = {NUM_STAGES{1'b0}};
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_total_nxt = w_total_inc;
        if (!w_active) begin
          w_start_nxt = f_onehot(r_cur);
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (w_cur_done) begin
          // Done is checked before timeout so a completing stage never errors.
          w_start_nxt = {NUM_STAGES{1'b0}};
          if (w_after[IDX_W]) begin
            w_cur_nxt = w_after[IDX_W-1:0];
          end else begin
            w_state_nxt = S_DONE;
          end
        end else if (w_timeout) begin
          w_start_nxt = {NUM_STAGES{1'b0}};
          w_state_nxt = S_ERROR;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE, S_ERROR: begin
        w_start_nxt = {NUM_STAGES{1'b0}};
        if (ap_continue) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_start_nxt = {NUM_STAGES{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
      r_mask  <= {NUM_STAGES{1'b0}};
      r_limit <= {CNT_W{1'b0}};
      r_cur   <= {IDX_W{1'b0}};
      r_start <= {NUM_STAGES{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_total <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_limit <= w_limit_nxt;
      r_cur   <= w_cur_nxt;
      r_start <= w_start_nxt;
      r_cnt   <= w_cnt_nxt;
      r_total <= w_total_nxt;
    end
  end

  assign ap_idle      = (r_state == S_IDLE);
  assign ap_done      = (r_state == S_DONE);
  assign err          = (r_state == S_ERROR);
  assign stage_start  = r_start;
  assign cur_stage    = r_cur;
  assign total_cycles = r_total;

endmodule

// File: tb/tb_layer_chain_sequencer.sv
// Directed bench for layer_chain_sequencer with behavioural kernel models on each stage.
module tb_layer_chain_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_continue;
  logic [7:0]  bypass_mask;
  logic [15:0] timeout_limit;
  logic [7:0]  stage_start;
  logic [7:0]  stage_done;
  logic [2:0]  cur_stage;
  logic        err;
  logic [15:0] total_cycles;

  logic [7:0]  k_done = 8'h00;
  logic [7:0]  force_done = 8'h00;
  int          k_cnt [8];
  int          lat [8];
  int          hi_cnt [8];
  logic [31:0] order_log = 32'h0;
  int          n_launch = 0;
  int          onehot_err = 0;
  int          gap_bad = 0;
  int          zero_run = 0;
  logic        had_burst = 1'b0;
  logic [7:0]  prev_start = 8'h00;

  int          n_chk = 0;
  int          n_pass = 0;

  assign stage_done = k_done | force_done;

  layer_chain_sequencer #(.NUM_STAGES(8), .IDX_W(3), .CNT_W(16)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_continue(ap_continue),
    .bypass_mask(bypass_mask), .timeout_limit(timeout_limit), .stage_start(stage_start),
    .stage_done(stage_done), .cur_stage(cur_stage), .err(err), .total_cycles(total_cycles)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [3:0] f_enc(input logic [7:0] v);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 8; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  // Kernel models (done on the lat-th cycle of start) plus launch-order/gap monitor.
  always @(negedge ap_clk) begin
    for (int i = 0; i < 8; i++) begin
      if (stage_start[i]) begin
        k_cnt[i]  <= k_cnt[i] + 1;
        k_done[i] <= (lat[i] != 0) && (k_cnt[i] + 1 == lat[i]);
        hi_cnt[i] <= hi_cnt[i] + 1;
      end else begin
        k_cnt[i]  <= 0;
        k_done[i] <= 1'b0;
      end
    end
    if (stage_start != 8'h00) begin
      if (!$onehot(stage_start)) onehot_err <= onehot_err + 1;
      if (prev_start == 8'h00) begin
        order_log <= {order_log[27:0], f_enc(stage_start)};
        n_launch  <= n_launch + 1;
        if (had_burst && zero_run != 1) gap_bad <= gap_bad + 1;
      end
      zero_run  <= 0;
      had_burst <= 1'b1;
    end else if (ap_idle) begin
      zero_run  <= 0;
      had_burst <= 1'b0;
    end else begin
      zero_run <= zero_run + 1;
    end
    prev_start <= stage_start;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_end(input string tag, input int max);
    int n;
    n = 0;
    while (!(ap_done || err) && n < max) begin
      step();
      n++;
    end
    chk(tag, {31'h0, ap_done | err}, 32'h1);
  endtask

  task automatic pulse_continue();
    ap_continue = 1'b1;
    step();
    ap_continue = 1'b0;
  endtask

  function automatic logic [7:0] started_since(input int snap [8]);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) if (hi_cnt[i] != snap[i]) m[i] = 1'b1;
    return m;
  endfunction

  initial begin
    int snap [8];
    int n0;
    int rdy_seen;
    int n;
    for (int i = 0; i < 8; i++) begin
      lat[i] = 3; k_cnt[i] = 0; hi_cnt[i] = 0;
    end
    ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
    bypass_mask = 8'h00; timeout_limit = 16'd0;
    step(); step();
    chk("rst_idle", {31'h0, ap_idle}, 32'h1);
    chk("rst_ready", {31'h0, ap_ready}, 32'h0);
    chk("rst_done", {31'h0, ap_done}, 32'h0);
    chk("rst_start", {24'h0, stage_start}, 32'h0);
    chk("rst_cur", {29'h0, cur_stage}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_total", {16'h0, total_cycles}, 32'h0);
    ap_rst_n = 1'b1;
    step();

    // T1: all stages, 3-cycle kernels
    for (int i = 0; i < 8; i++) snap[i] = hi_cnt[i];
    n0 = n_launch;
    ap_start = 1'b1;
    #1;
    chk("t1_ready", {31'h0, ap_ready}, 32'h1);
    step();
    ap_start = 1'b0;
    chk("t1_first_start", {24'h0, stage_start}, 32'h01);
    chk("t1_ready_drop", {31'h0, ap_ready}, 32'h0);
    wait_end("t1_end", 200);
    chk("t1_done", {31'h0, ap_done}, 32'h1);
    chk("t1_total", {16'h0, total_cycles}, 32'd31);
    chk("t1_cur", {29'h0, cur_stage}, 32'd7);
    chk("t1_launches", n_launch - n0, 32'd8);
    chk("t1_order", order_log, 32'h01234567);
    chk("t1_started", {24'h0, started_since(snap)}, 32'hFF);
    chk("t1_gaps", gap_bad, 32'd0);

    // T5: ap_start held while DONE is not acknowledged
    ap_start = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ap_ready) rdy_seen++;
    end
    chk("t5_no_ready", rdy_seen, 32'd0);
    chk("t5_still_done", {31'h0, ap_done}, 32'h1);
    bypass_mask = 8'hA5;
    pulse_continue();
    chk("t5_idle", {31'h0, ap_idle}, 32'h1);
    chk("t5_ready", {31'h0, ap_ready}, 32'h1);
    for (int i = 0; i < 8; i++) snap[i] = hi_cnt[i];
    n0 = n_launch;
    step();
    ap_start = 1'b0;

    // T2: mask A5 leaves stages 1,3,4,6
    chk("t2_first_start", {24'h0, stage_start}, 32'h02);
    wait_end("t2_end", 200);
    chk("t2_cur", {29'h0, cur_stage}, 32'd6);
    chk("t2_started", {24'h0, started_since(snap)}, 32'h5A);
    chk("t2_order", {16'h0, order_log[15:0]}, 32'h1346);
    chk("t2_launches", n_launch - n0, 32'd4);
    chk("t2_total", {16'h0, total_cycles}, 32'd15);
    pulse_continue();

    // T3: everything bypassed
    for (int i = 0; i < 8; i++) snap[i] = hi_cnt[i];
    bypass_mask = 8'hFF;
    ap_start = 1'b1;
    #1;
    chk("t3_ready", {31'h0, ap_ready}, 32'h1);
    step();
    ap_start = 1'b0;
    chk("t3_done", {31'h0, ap_done}, 32'h1);
    chk("t3_total", {16'h0, total_cycles}, 32'd0);
    chk("t3_start", {24'h0, stage_start}, 32'h0);
    chk("t3_started", {24'h0, started_since(snap)}, 32'h00);
    pulse_continue();

    // T4: stage 2 hangs, limit 10
    for (int i = 0; i < 8; i++) snap[i] = hi_cnt[i];
    bypass_mask = 8'h00;
    timeout_limit = 16'd10;
    lat[2] = 0;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    wait_end("t4_end", 200);
    chk("t4_err", {31'h0, err}, 32'h1);
    chk("t4_done", {31'h0, ap_done}, 32'h0);
    chk("t4_cur", {29'h0, cur_stage}, 32'd2);
    chk("t4_start", {24'h0, stage_start}, 32'h0);
    chk("t4_hung_cycles", hi_cnt[2] - snap[2], 32'd10);
    chk("t4_total", {16'h0, total_cycles}, 32'd18);
    pulse_continue();
    chk("t4_err_clear", {31'h0, err}, 32'h0);
    chk("t4_idle", {31'h0, ap_idle}, 32'h1);
    lat[2] = 3;

    // Done and timeout coincide: limit 3 with 3-cycle kernels on stages 0,1
    bypass_mask = 8'hFC;
    timeout_limit = 16'd3;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    wait_end("tie_end", 200);
    chk("tie_done", {31'h0, ap_done}, 32'h1);
    chk("tie_err", {31'h0, err}, 32'h0);
    chk("tie_total", {16'h0, total_cycles}, 32'd7);
    chk("tie_cur", {29'h0, cur_stage}, 32'd1);
    pulse_continue();

    // T6: reset while stage 4 active
    bypass_mask = 8'h00;
    timeout_limit = 16'd0;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    n = 0;
    while (stage_start != 8'h10 && n < 200) begin
      step();
      n++;
    end
    chk("t6_reach4", {24'h0, stage_start}, 32'h10);
    ap_rst_n = 1'b0;
    step();
    ap_rst_n = 1'b1;
    chk("t6_idle", {31'h0, ap_idle}, 32'h1);
    chk("t6_start", {24'h0, stage_start}, 32'h0);
    chk("t6_cur", {29'h0, cur_stage}, 32'h0);
    chk("t6_total", {16'h0, total_cycles}, 32'h0);
    chk("t6_done", {31'h0, ap_done}, 32'h0);
    force_done = 8'h10;
    step();
    step();
    force_done = 8'h00;
    chk("t6_ignored_start", {24'h0, stage_start}, 32'h0);
    chk("t6_ignored_idle", {31'h0, ap_idle}, 32'h1);
    chk("onehot_all", onehot_err, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
